// File: rtl/demux_shkrimi_3bit.sv
// Write-back demultiplexer: buffers up to two {address, data} writes and issues
// them in order as a registered one-hot write enable plus data, honouring a stall.
module demux_shkrimi_3bit #(
  parameter int GJERESIA = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Hyrja_Valid,
  input  logic [2:0]          Hyrja_Adresa,
  input  logic [GJERESIA-1:0] Hyrja_Te_dhenat,
  output logic                Hyrja_Gati,
  input  logic                Ndalo,
  output logic [7:0]          Dalja_WE,
  output logic [GJERESIA-1:0] Dalja_Te_dhenat,
  output logic [7:0]          Dalja_Zene,
  output logic [1:0]          Dalja_Numri
);

  logic [1:0]          count_q, count_d;
  logic                wrPtr_q, wrPtr_d;
  logic                rdPtr_q, rdPtr_d;
  logic [7:0]          we_q, we_d;
  logic [GJERESIA-1:0] dataOut_q, dataOut_d;
  logic [2:0]          adrMem_q  [2];
  logic [GJERESIA-1:0] dataMem_q [2];
  logic                accept;
  logic                issue;
  logic [7:0]          zene;

  assign Hyrja_Gati = (count_q < 2'd2) && !Reset;
  assign accept     = Hyrja_Valid && Hyrja_Gati;
  // Issue looks only at registered occupancy, so a write landing in an empty buffer waits one edge.
  assign issue      = (count_q != 2'd0) && !Ndalo;

  always_comb begin
    count_d   = count_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    we_d      = 8'h00;
    dataOut_d = dataOut_q;
    if (issue) begin
      rdPtr_d   = ~rdPtr_q;
      we_d      = 8'h01 << adrMem_q[rdPtr_q];
      dataOut_d = dataMem_q[rdPtr_q];
    end
    if (accept) begin
      wrPtr_d = ~wrPtr_q;
    end
    case ({accept, issue})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q   <= 2'd0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      we_q      <= 8'h00;
      dataOut_q <= '0;
    end else begin
      count_q   <= count_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      we_q      <= we_d;
      dataOut_q <= dataOut_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge Clock) begin
    if (accept) begin
      adrMem_q[wrPtr_q]  <= Hyrja_Adresa;
      dataMem_q[wrPtr_q] <= Hyrja_Te_dhenat;
    end
  end

  always_comb begin
    zene = 8'h00;
    if (count_q != 2'd0) begin
      zene = zene | (8'h01 << adrMem_q[rdPtr_q]);
    end
    if (count_q == 2'd2) begin
      zene = zene | (8'h01 << adrMem_q[~rdPtr_q]);
    end
  end

  assign Dalja_WE        = we_q;
  assign Dalja_Te_dhenat = dataOut_q;
  assign Dalja_Zene      = zene;
  assign Dalja_Numri     = count_q;

endmodule

// File: tb/tb_demux_shkrimi_3bit.sv
// Bench for demux_shkrimi_3bit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux_shkrimi_3bit;
  localparam int W = 16;

  logic         Clock;
  logic         Reset;
  logic         Hyrja_Valid;
  logic [2:0]   Hyrja_Adresa;
  logic [W-1:0] Hyrja_Te_dhenat;
  logic         Hyrja_Gati;
  logic         Ndalo;
  logic [7:0]   Dalja_WE;
  logic [W-1:0] Dalja_Te_dhenat;
  logic [7:0]   Dalja_Zene;
  logic [1:0]   Dalja_Numri;

  demux_shkrimi_3bit #(.GJERESIA(W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Hyrja_Valid(Hyrja_Valid),
    .Hyrja_Adresa(Hyrja_Adresa),
    .Hyrja_Te_dhenat(Hyrja_Te_dhenat),
    .Hyrja_Gati(Hyrja_Gati),
    .Ndalo(Ndalo),
    .Dalja_WE(Dalja_WE),
    .Dalja_Te_dhenat(Dalja_Te_dhenat),
    .Dalja_Zene(Dalja_Zene),
    .Dalja_Numri(Dalja_Numri)
  );

  typedef struct packed {
    logic [2:0]   adr;
    logic [W-1:0] data;
  } entry_t;

  entry_t       q[$];
  logic [7:0]   expWe;
  logic [W-1:0] expData;
  bit           modelReady;
  int           checks;
  int           errors;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [W-1:0] d,
                               input logic n, input logic r);
    Hyrja_Valid     = v;
    Hyrja_Adresa    = a;
    Hyrja_Te_dhenat = d;
    Ndalo           = n;
    Reset           = r;
  endtask

  task automatic cycle();
    @(posedge Clock);
    #2;
  endtask

  // Reference: a FIFO of pending writes; each edge pops the head if not stalled, then pushes an accepted offer.
  always @(posedge Clock) begin
    bit     canIssue;
    bit     canAccept;
    entry_t e;
    if (Reset) begin
      q.delete();
      expWe      = 8'h00;
      expData    = '0;
      modelReady = 1'b1;
    end else begin
      canIssue  = (q.size() > 0) && !Ndalo;
      canAccept = Hyrja_Valid && (q.size() < 2);
      if (canIssue) begin
        e       = q.pop_front();
        expWe   = 8'h01 << e.adr;
        expData = e.data;
      end else begin
        expWe = 8'h00;
      end
      if (canAccept) begin
        q.push_back({Hyrja_Adresa, Hyrja_Te_dhenat});
      end
    end
  end

  always @(negedge Clock) begin
    logic [7:0] z;
    if (modelReady) begin
      z = 8'h00;
      foreach (q[i]) z = z | (8'h01 << q[i].adr);
      checkOutput("we", Dalja_WE, expWe);
      checkOutput("data", Dalja_Te_dhenat, expData);
      checkOutput("numri", Dalja_Numri, q.size());
      checkOutput("zene", Dalja_Zene, z);
      checkOutput("gati", Hyrja_Gati, (q.size() < 2) && !Reset);
      checkOutput("weOnehot", $countones(Dalja_WE) <= 1, 1);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    modelReady = 1'b0;
    expWe      = 8'h00;
    expData    = '0;
    applyStimulus(0, 3'd0, '0, 0, 1);
    cycle();
    cycle();
    checkOutput("rstWe", Dalja_WE, 8'h00);
    checkOutput("rstNumri", Dalja_Numri, 2'd0);
    checkOutput("rstZene", Dalja_Zene, 8'h00);
    checkOutput("rstGatiHeld", Hyrja_Gati, 1'b0);
    applyStimulus(0, 3'd0, '0, 0, 0);
    #1;
    checkOutput("rstGati", Hyrja_Gati, 1'b1);

    // Single write
    applyStimulus(1, 3'd5, 16'hA5A5, 0, 0);
    cycle();
    checkOutput("singleNoBypass", Dalja_WE, 8'h00);
    checkOutput("singleZene", Dalja_Zene, 8'h20);
    applyStimulus(0, 3'd0, '0, 0, 0);
    cycle();
    checkOutput("singleWe", Dalja_WE, 8'h20);
    checkOutput("singleData", Dalja_Te_dhenat, 16'hA5A5);
    cycle();
    checkOutput("singleWeOff", Dalja_WE, 8'h00);
    checkOutput("singleDataHold", Dalja_Te_dhenat, 16'hA5A5);

    // Fill under stall, third offer ignored
    applyStimulus(1, 3'd1, 16'h0001, 1, 0);
    cycle();
    applyStimulus(1, 3'd7, 16'h0007, 1, 0);
    cycle();
    checkOutput("fillNumri", Dalja_Numri, 2'd2);
    checkOutput("fillGati", Hyrja_Gati, 1'b0);
    checkOutput("fillZene", Dalja_Zene, 8'h82);
    applyStimulus(1, 3'd4, 16'h0004, 1, 0);
    cycle();
    checkOutput("fillIgnored", Dalja_Numri, 2'd2);
    checkOutput("fillZeneKept", Dalja_Zene, 8'h82);
    applyStimulus(0, 3'd0, '0, 0, 0);
    cycle();
    checkOutput("fillWe1", Dalja_WE, 8'h02);
    checkOutput("fillData1", Dalja_Te_dhenat, 16'h0001);
    checkOutput("fillZene1", Dalja_Zene, 8'h80);
    cycle();
    checkOutput("fillWe2", Dalja_WE, 8'h80);
    checkOutput("fillData2", Dalja_Te_dhenat, 16'h0007);
    cycle();
    checkOutput("fillEmpty", Dalja_Numri, 2'd0);

    // Same address twice
    applyStimulus(1, 3'd3, 16'h1111, 1, 0);
    cycle();
    applyStimulus(1, 3'd3, 16'h2222, 1, 0);
    cycle();
    checkOutput("sameZene", Dalja_Zene, 8'h08);
    applyStimulus(0, 3'd0, '0, 0, 0);
    cycle();
    checkOutput("sameWe1", Dalja_WE, 8'h08);
    checkOutput("sameData1", Dalja_Te_dhenat, 16'h1111);
    checkOutput("sameZeneHeld", Dalja_Zene, 8'h08);
    cycle();
    checkOutput("sameWe2", Dalja_WE, 8'h08);
    checkOutput("sameData2", Dalja_Te_dhenat, 16'h2222);
    checkOutput("sameZeneClear", Dalja_Zene, 8'h00);

    // Streaming six writes back to back
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 3'(i), 16'(16'h0100 + i), 0, 0);
      cycle();
      checkOutput("streamNumri", Dalja_Numri, 2'd1);
      if (i > 0) checkOutput("streamWe", Dalja_WE, 8'h01 << (i - 1));
    end
    applyStimulus(0, 3'd0, '0, 0, 0);
    cycle();
    checkOutput("streamWeLast", Dalja_WE, 8'h20);
    checkOutput("streamDataLast", Dalja_Te_dhenat, 16'h0105);

    // Reset while full, with a pending offer and release of stall
    applyStimulus(1, 3'd6, 16'h0666, 1, 0);
    cycle();
    applyStimulus(1, 3'd2, 16'h0222, 1, 0);
    cycle();
    checkOutput("rstMidFull", Dalja_Numri, 2'd2);
    applyStimulus(1, 3'd4, 16'h0444, 0, 1);
    cycle();
    checkOutput("rstMidWe", Dalja_WE, 8'h00);
    checkOutput("rstMidNumri", Dalja_Numri, 2'd0);
    checkOutput("rstMidZene", Dalja_Zene, 8'h00);
    checkOutput("rstMidData", Dalja_Te_dhenat, 16'h0000);
    applyStimulus(0, 3'd0, '0, 0, 0);
    cycle();
    checkOutput("rstMidNoIssue1", Dalja_WE, 8'h00);
    cycle();
    checkOutput("rstMidNoIssue2", Dalja_WE, 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) != 0, 3'($urandom), W'($urandom),
                    ($urandom % 3) == 0, ($urandom % 64) == 0);
      cycle();
    end
    applyStimulus(0, 3'd0, '0, 0, 0);
    cycle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_shkrimi_3bit.md
DEMUX_SHKRIMI_3BIT -- requirements
Module: demux_shkrimi_3bit

Interface
REQ-001 The block SHALL have parameter GJERESIA, default 16, giving the width of the write-back data path.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Hyrja_Valid, input, 1 bit: the producer offers a write this cycle.
REQ-005 The block SHALL have port Hyrja_Adresa, input, 3 bits: destination register index, 0-7.
REQ-006 The block SHALL have port Hyrja_Te_dhenat, input, GJERESIA bits: write data.
REQ-007 The block SHALL have port Hyrja_Gati, output, 1 bit: the block can accept a write this cycle.
REQ-008 The block SHALL have port Ndalo, input, 1 bit: stall; while high, no write is issued to the register file.
REQ-009 The block SHALL have port Dalja_WE, output, 8 bits: registered one-hot write enable, bit i selects register i.
REQ-010 The block SHALL have port Dalja_Te_dhenat, output, GJERESIA bits: registered write data for the register file.
REQ-011 The block SHALL have port Dalja_Zene, output, 8 bits: bit i is high while any buffered, not-yet-issued write targets register i.
REQ-012 The block SHALL have port Dalja_Numri, output, 2 bits: current buffer occupancy, 0-2.

Function
REQ-013 The block SHALL contain a 2-entry FIFO of {address, data} pairs, managed with a write pointer, a read pointer and an occupancy count.
REQ-014 Hyrja_Gati SHALL equal (Dalja_Numri < 2) AND NOT Reset, driven combinationally from registered state.
REQ-015 A write SHALL be accepted on a rising edge only when Hyrja_Valid = 1 and Hyrja_Gati = 1; the pair is stored at the write pointer, and the write pointer increments modulo 2.
REQ-016 When Hyrja_Valid = 1 and Hyrja_Gati = 0, the offer SHALL be ignored with no state change; the producer holds its values.
REQ-017 An issue SHALL occur on a rising edge when Dalja_Numri > 0 and Ndalo = 0: the head entry pops, and the read pointer increments modulo 2.
REQ-018 On an issue, after the same edge, Dalja_WE SHALL equal the one-hot decode of the popped address, and Dalja_Te_dhenat SHALL equal the popped data.
REQ-019 On any edge without an issue, Dalja_WE SHALL be 8'h00, and Dalja_Te_dhenat SHALL hold its previous value.
REQ-020 Dalja_WE SHALL never have more than one bit set.
REQ-021 Latency: a write accepted at edge N into an empty buffer, with Ndalo = 0, SHALL appear on Dalja_WE after edge N+1.
REQ-022 The buffer SHALL NOT bypass input to output: an accept into an empty buffer and an issue never occur on the same edge.
REQ-023 On a simultaneous accept and issue, the count SHALL be unchanged and both pointers SHALL advance; this is only possible at count 1.
REQ-024 At count 2, with Ndalo = 0, an issue SHALL occur; an accept SHALL NOT occur on that edge, because Hyrja_Gati = 0.
REQ-025 Issue order SHALL equal accept order, including two writes to the same address.
REQ-026 Dalja_Zene SHALL be the combinational OR of the one-hot decodes of all occupied entries; it is 0 when count = 0.
REQ-027 Dalja_Zene SHALL clear a bit on the edge its last targeting entry issues, not earlier.
REQ-028 The count SHALL never exceed 2 or go below 0 under any input sequence.

Reset
REQ-029 While Reset = 1 at a rising edge, the count, both pointers and Dalja_WE SHALL become 0, and Dalja_Te_dhenat SHALL become all zeros.
REQ-030 Reset SHALL override simultaneous Hyrja_Valid and issue conditions: buffered entries are discarded, and no write is issued after the reset edge.
REQ-031 After reset: Hyrja_Gati = 1 (once Reset is low), Dalja_Zene = 8'h00, Dalja_Numri = 0.

Verification
REQ-032 Single write: accept adr 5, data 16'hA5A5, Ndalo = 0 -> next edge Dalja_WE = 8'h20 and Dalja_Te_dhenat = 16'hA5A5; the edge after that, Dalja_WE = 8'h00.
REQ-033 Fill under stall: Ndalo = 1, accept adr 1 / 16'h0001 then adr 7 / 16'h0007 -> Dalja_Numri = 2, Hyrja_Gati = 0, Dalja_Zene = 8'h82. A third offer is ignored. Release Ndalo -> WE = 8'h02, then 8'h80, in order.
REQ-034 Same-address pair: accept adr 3 twice, with 16'h1111 then 16'h2222, under stall; release -> two consecutive WE = 8'h08 pulses with the data in order. Dalja_Zene bit 3 stays high until the second issue.
REQ-035 Streaming: Hyrja_Valid held high for 6 cycles with adr 0-5 and Ndalo = 0 -> all 6 issue exactly once, in order, and the count never exceeds 2.
REQ-036 Reset mid-operation: count = 2 under stall, Reset pulsed for one edge -> WE = 0, Numri = 0, Zene = 0, and the discarded entries never appear.
